// File: rtl/stochastic_adc_backend_pr.sv
// Purpose : stochastic ADC slice back-end. It converts a TDC thermometer word and the
//           PFD sign into an unsigned count and a signed result. The thermometer sense can
//           be inverted, bubbles in the word are flagged, and an offset-calibration
//           averager is available on request.
// Latency : a sample captured at edge k is presented after edge k+1+NPIPE+ret_dly.
// Backpr. : none. The block accepts one sample per cycle and always produces one; valid_out
//           qualifies the result.
// Ports   : clk/rst (synchronous, active-high); therm_in/sign_in/valid_in carry the sample;
//           en_phase_reverse inverts the thermometer sense; ret_dly adds 0..3 cycles of
//           retiming; cal_start launches an average. The results are data_out (count),
//           sign_out, sdata_out (signed), valid_out and therm_err. The calibration
//           interface is cal_busy, cal_done and cal_mean.
module stochastic_adc_backend_pr #(
  parameter int NADC      = 8,
  parameter int NPIPE     = 2,
  parameter int NACC_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2**NADC-2:0]   therm_in,
  input  logic                 sign_in,
  input  logic                 valid_in,
  input  logic                 en_phase_reverse,
  input  logic [1:0]           ret_dly,
  input  logic                 cal_start,
  output logic [NADC-1:0]      data_out,
  output logic                 sign_out,
  output logic [NADC:0]        sdata_out,
  output logic                 valid_out,
  output logic                 therm_err,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic [NADC:0]        cal_mean
);

  localparam int W  = 2**NADC - 1;
  localparam int WP = 2**NADC;          // padded to a power of two for the tree
  localparam int Q  = WP / 4;           // quarter width, first tree level
  localparam int AW = NADC + 1 + NACC_LOG2;
  localparam int OW = 3 + NADC + NADC + 1;

  // ---------------- input stage and phase-reverse synchroniser ----------------
  logic [W-1:0] therm_q;
  logic         sign_q, valid_q, pr_q1, pr_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      therm_q <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      pr_q1   <= 1'b0;
      pr_q2   <= 1'b0;
    end else begin
      pr_q1   <= en_phase_reverse;
      pr_q2   <= pr_q1;
      // Inversion is applied as the sample is captured, so the two-flop
      // synchroniser sets the exact sample boundary of the switch.
      therm_q <= pr_q2 ? ~therm_in : therm_in;
      sign_q  <= sign_in;
      valid_q <= valid_in;
    end
  end

  // A bubble is a set bit sitting above a clear bit.
  logic bubble;
  assign bubble = |(therm_q[W-1:1] & ~therm_q[W-2:0]);

  logic [WP-1:0] therm_pad;
  assign therm_pad = {1'b0, therm_q};

  function automatic logic [NADC-2:0] pop_q(input logic [Q-1:0] v);
    logic [NADC-2:0] c;
    c = '0;
    for (int i = 0; i < Q; i++) c = c + (NADC-1)'(v[i]);
    return c;
  endfunction

  // ---------------- popcount tree: quarters -> halves -> total ----------------
  // Each level may be registered. The side band {valid, sign, err} travels with
  // its level so that it always stays aligned with the count.
  logic [3:0][NADC-2:0] l0_d, l0_q;
  logic [2:0]           l0s_d, l0s_q;
  logic [1:0][NADC-1:0] l1_d, l1_q;
  logic [2:0]           l1s_q;
  logic [NADC-1:0]      l2_d, l2_q;
  logic [2:0]           l2s_q;

  always_comb begin
    for (int i = 0; i < 4; i++) l0_d[i] = pop_q(therm_pad[i*Q +: Q]);
  end
  assign l0s_d = {valid_q, sign_q, bubble};

  generate
    if (NPIPE >= 1) begin : g_st0_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          l0_q  <= '0;
          l0s_q <= '0;
        end else begin
          l0_q  <= l0_d;
          l0s_q <= l0s_d;
        end
      end
    end else begin : g_st0_comb
      assign l0_q  = l0_d;
      assign l0s_q = l0s_d;
    end
  endgenerate

  assign l1_d[0] = {1'b0, l0_q[0]} + {1'b0, l0_q[1]};
  assign l1_d[1] = {1'b0, l0_q[2]} + {1'b0, l0_q[3]};

  generate
    if (NPIPE >= 2) begin : g_st1_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          l1_q  <= '0;
          l1s_q <= '0;
        end else begin
          l1_q  <= l1_d;
          l1s_q <= l0s_q;
        end
      end
    end else begin : g_st1_comb
      assign l1_q  = l1_d;
      assign l1s_q = l0s_q;
    end
  endgenerate

  // The padded top bit is always 0, so the total fits in NADC bits.
  assign l2_d = l1_q[0] + l1_q[1];

  generate
    if (NPIPE >= 3) begin : g_st2_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          l2_q  <= '0;
          l2s_q <= '0;
        end else begin
          l2_q  <= l2_d;
          l2s_q <= l1s_q;
        end
      end
    end else begin : g_st2_comb
      assign l2_q  = l2_d;
      assign l2s_q = l1s_q;
    end
  endgenerate

  // ---------------- output register and retiming delay line ----------------
  logic [NADC:0] mag, sdata_d;
  assign mag     = {1'b0, l2_q};
  assign sdata_d = l2s_q[1] ? mag : -mag;   // -0 == 0, so a zero count is sign-free

  logic [OW-1:0] out_r;
  logic [OW-1:0] dly [0:2];
  logic [OW-1:0] sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= '0;
      dly[0] <= '0;
      dly[1] <= '0;
      dly[2] <= '0;
    end else begin
      out_r  <= {l2s_q[2], l2s_q[0], l2s_q[1], l2_q, sdata_d};
      dly[0] <= out_r;
      dly[1] <= dly[0];
      dly[2] <= dly[1];
    end
  end

  always_comb begin
    case (ret_dly)
      2'd0:    sel = out_r;
      2'd1:    sel = dly[0];
      2'd2:    sel = dly[1];
      default: sel = dly[2];
    endcase
  end

  assign {valid_out, therm_err, sign_out, data_out, sdata_out} = sel;

  // ---------------- calibration averager ----------------
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} cal_state_t;

  cal_state_t           cal_state;
  logic [AW-1:0]        acc, acc_nxt;
  logic [NACC_LOG2-1:0] smp_cnt;

  assign acc_nxt = acc + {{NACC_LOG2{sdata_out[NADC]}}, sdata_out};

  always_ff @(posedge clk) begin
    if (rst) begin
      cal_state <= IDLE;
      acc       <= '0;
      smp_cnt   <= '0;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      cal_mean  <= '0;
    end else begin
      case (cal_state)
        IDLE: begin
          cal_done <= 1'b0;
          if (cal_start) begin
            acc       <= '0;
            smp_cnt   <= '0;
            cal_busy  <= 1'b1;
            cal_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (valid_out) begin
            acc     <= acc_nxt;
            smp_cnt <= smp_cnt + NACC_LOG2'(1);
            if (smp_cnt == '1) begin
              // Taking the top bits is an arithmetic shift, i.e. floor toward -inf.
              cal_mean  <= acc_nxt[AW-1:NACC_LOG2];
              cal_busy  <= 1'b0;
              cal_done  <= 1'b1;
              cal_state <= DONE;
            end
          end
        end
        default: begin
          cal_done  <= 1'b0;
          cal_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stochastic_adc_backend_pr.sv
// Bench for stochastic_adc_backend_pr (NADC=8, NPIPE=2, NACC_LOG2=4). It uses directed
// vectors and a per-cycle behavioural model held in input-history arrays.
module tb_stochastic_adc_backend_pr;
  localparam int NADC = 8, NPIPE = 2, NACC_LOG2 = 4;
  localparam int W = 255, MAXC = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   therm_in;
  logic           sign_in, valid_in, en_phase_reverse, cal_start;
  logic [1:0]     ret_dly;
  logic [7:0]     data_out;
  logic           sign_out, valid_out, therm_err, cal_busy, cal_done;
  logic [8:0]     sdata_out, cal_mean;

  stochastic_adc_backend_pr #(.NADC(NADC), .NPIPE(NPIPE), .NACC_LOG2(NACC_LOG2)) dut (
    .clk(clk), .rst(rst), .therm_in(therm_in), .sign_in(sign_in), .valid_in(valid_in),
    .en_phase_reverse(en_phase_reverse), .ret_dly(ret_dly), .cal_start(cal_start),
    .data_out(data_out), .sign_out(sign_out), .sdata_out(sdata_out), .valid_out(valid_out),
    .therm_err(therm_err), .cal_busy(cal_busy), .cal_done(cal_done), .cal_mean(cal_mean));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", nm, got, exp, cyc);
  endtask

  // Input history, one entry per rising edge (index = edge number).
  int           cyc = 0;
  logic [W-1:0] th_a [0:MAXC-1];
  logic         sg_a [0:MAXC-1];
  logic         vl_a [0:MAXC-1];
  logic         en_a [0:MAXC-1];
  logic         rs_a [0:MAXC-1];
  logic         cs_a [0:MAXC-1];
  logic [1:0]   rd_a [0:MAXC-1];

  always @(posedge clk) begin
    if (cyc < MAXC - 1) begin
      th_a[cyc+1] <= therm_in;
      sg_a[cyc+1] <= sign_in;
      vl_a[cyc+1] <= valid_in;
      en_a[cyc+1] <= en_phase_reverse;
      rs_a[cyc+1] <= rst;
      cs_a[cyc+1] <= cal_start;
      rd_a[cyc+1] <= ret_dly;
    end
    cyc <= cyc + 1;
  end

  // Calibration model state and the expected output of the previous cycle.
  logic       m_busy = 1'b0, m_done = 1'b0;
  logic [8:0] m_mean = '0;
  int         m_sum = 0, m_n = 0, msh;
  logic       p_ev = 1'b0;
  logic [8:0] p_sd = '0;

  always @(negedge clk) begin : compare
    int         e, c;
    logic       ev, pr, eerr, esg;
    logic [7:0] ecnt;
    logic [8:0] esd;
    logic [W-1:0] t;
    if (cyc >= 1 && cyc < MAXC) begin
      e = cyc;
      // Calibration: the output visible before edge e is summed at edge e.
      if (rs_a[e]) begin
        m_busy = 1'b0; m_done = 1'b0; m_mean = '0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (!m_busy) begin
        if (cs_a[e]) begin m_busy = 1'b1; m_sum = 0; m_n = 0; end
      end else if (p_ev) begin
        m_sum = m_sum + $signed(p_sd);
        m_n++;
        if (m_n == 16) begin
          m_busy = 1'b0; m_done = 1'b1;
          msh = m_sum >>> 4;
          m_mean = msh[8:0];
        end
      end
      // Sample captured at edge c = e - 3 - ret_dly is now on the outputs.
      c = e - 3 - int'(rd_a[e]);
      ev = 1'b0; esd = '0; ecnt = '0; eerr = 1'b0; esg = 1'b0;
      if (c >= 1 && vl_a[c]) begin
        ev = 1'b1;
        for (int j = c; j <= e; j++) if (rs_a[j]) ev = 1'b0;
      end
      if (ev) begin
        pr = 1'b0;
        if (c >= 3) pr = en_a[c-2] && !rs_a[c-1] && !rs_a[c-2];
        t = pr ? ~th_a[c] : th_a[c];
        ecnt = 8'($countones(t));
        for (int i = 0; i < W - 1; i++) if (t[i+1] && !t[i]) eerr = 1'b1;
        esg = sg_a[c];
        esd = esg ? {1'b0, ecnt} : -{1'b0, ecnt};
        chk("m_data_out", 32'(data_out), 32'(ecnt));
        chk("m_sdata_out", 32'(sdata_out), 32'(esd));
        chk("m_sign_out", 32'(sign_out), 32'(esg));
        chk("m_therm_err", 32'(therm_err), 32'(eerr));
      end
      if (rs_a[e]) begin
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_sdata_out", 32'(sdata_out), 0);
        chk("rst_sign_out", 32'(sign_out), 0);
        chk("rst_therm_err", 32'(therm_err), 0);
      end
      chk("m_valid_out", 32'(valid_out), 32'(ev));
      chk("m_cal_busy", 32'(cal_busy), 32'(m_busy));
      chk("m_cal_done", 32'(cal_done), 32'(m_done));
      chk("m_cal_mean", 32'(cal_mean), 32'(m_mean));
      p_ev = ev;
      p_sd = esd;
    end
  end

  function automatic logic [W-1:0] ones(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      cal_start = 1'b0;
    end
  endtask

  // Drive one valid sample, then find the cycle in which it appears and check it.
  task automatic send_chk(input string nm, input logic [W-1:0] t, input logic s,
                          input int exp_lat, input logic [7:0] ed, input logic [8:0] esd,
                          input logic eerr);
    int got;
    got = -1;
    @(negedge clk);
    therm_in = t; sign_in = s; valid_in = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (got < 0 && valid_out) begin
        got = j;
        chk({nm, "_data"}, 32'(data_out), 32'(ed));
        chk({nm, "_sdata"}, 32'(sdata_out), 32'(esd));
        chk({nm, "_err"}, 32'(therm_err), 32'(eerr));
      end
    end
    chk({nm, "_latency"}, got, exp_lat);
  endtask

  // Wait a bounded time for cal_done. Check the mean at the pulse, and that only one
  // pulse is seen.
  task automatic wait_done(input string nm, input logic [8:0] exp_mean);
    int dn;
    logic found;
    dn = 0; found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (cal_done) begin
        dn++;
        if (!found) begin
          found = 1'b1;
          chk({nm, "_mean"}, 32'(cal_mean), 32'(exp_mean));
          chk({nm, "_busy_at_done"}, 32'(cal_busy), 0);
        end
      end
    end
    chk({nm, "_done_pulses"}, dn, 1);
  endtask

  initial begin
    rst = 1'b1; ret_dly = 2'd0; en_phase_reverse = 1'b0;
    sign_in = 1'b1; valid_in = 1'b1; cal_start = 1'b1;
    for (int i = 0; i < W; i++) therm_in[i] = 1'($urandom_range(0, 1));
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < W; i++) therm_in[i] = 1'($urandom_range(0, 1));
      sign_in = 1'($urandom_range(0, 1));
      valid_in = 1'($urandom_range(0, 1));
      cal_start = 1'($urandom_range(0, 1));
      en_phase_reverse = 1'($urandom_range(0, 1));
    end
    rst = 1'b0; valid_in = 1'b0; cal_start = 1'b0; en_phase_reverse = 1'b0;
    idle(6);

    send_chk("lat0", ones(100), 1'b1, 3, 8'd100, 9'd100, 1'b0);
    idle(2); ret_dly = 2'd3; idle(2);
    send_chk("lat3", ones(100), 1'b1, 6, 8'd100, 9'd100, 1'b0);
    idle(2); ret_dly = 2'd0; idle(2);
    send_chk("neg37", ones(37), 1'b0, 3, 8'd37, 9'h1DB, 1'b0);
    send_chk("neg255", ones(255), 1'b0, 3, 8'd255, 9'h101, 1'b0);
    send_chk("zero_neg", '0, 1'b0, 3, 8'd0, 9'd0, 1'b0);
    send_chk("zero_pos", '0, 1'b1, 3, 8'd0, 9'd0, 1'b0);
    send_chk("bubble", 255'h3EF, 1'b1, 3, 8'd9, 9'd9, 1'b1);
    send_chk("clean10", 255'h3FF, 1'b1, 3, 8'd10, 9'd10, 1'b0);

    // Phase reverse: stream 100 ones. The output seen at iteration i belongs to the
    // sample driven at iteration i-4.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 8)  chk("pr_before", 32'(data_out), 100);
      if (i == 9)  chk("pr_after", 32'(data_out), 155);
      if (i == 14) chk("pr_hold", 32'(data_out), 155);
      if (i == 15) chk("pr_back", 32'(data_out), 100);
      therm_in = ones(100); sign_in = 1'b1; valid_in = 1'b1;
      en_phase_reverse = (i >= 3 && i < 9);
    end
    en_phase_reverse = 1'b0;
    idle(8);

    // Calibration 1: alternating +10 / -3 gives a sum of 56, so the mean is 3.
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      therm_in = (i % 2 == 0) ? ones(10) : ones(3);
      sign_in = (i % 2 == 0);
      valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    wait_done("cal_alt", 9'd3);
    idle(5);
    chk("cal_hold", 32'(cal_mean), 3);

    // Calibration 2: sixteen samples of -1, with a cal_start pulse while busy.
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      therm_in = ones(1); sign_in = 1'b0; valid_in = 1'b1;
      cal_start = (i == 8);
      @(negedge clk);
    end
    valid_in = 1'b0; cal_start = 1'b0;
    wait_done("cal_m1", 9'h1FF);

    // Calibration 3: reset partway through the accumulation.
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      therm_in = ones(10); sign_in = 1'b1; valid_in = 1'b1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    idle(5);
    chk("cal_busy_mid", 32'(cal_busy), 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("cal_rst_busy", 32'(cal_busy), 0);
    chk("cal_rst_mean", 32'(cal_mean), 0);
    begin
      int dn;
      dn = 0;
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (cal_done) dn++;
      end
      chk("cal_rst_no_done", dn, 0);
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stochastic_adc_backend_pr.md
Name: stochastic_adc_backend_pr

Overview:
- Parametrised digital back-end for the stochastic ADC slice. It takes over from the fixed 8-bit adder, phase-reverse and retimer chain.
- Converts the TDC thermometer word plus PFD sign into magnitude and signed results, through a configurable pipelined popcount and a selectable retiming delay.
- Adds two behaviours the previous slice lacks: thermometer bubble flagging and an on-demand offset-calibration averager.
- Sits between the TDC flop bank and the per-slice ADC data bus.

Parameters:
- NADC, 8, output magnitude width; thermometer input is 2**NADC-1 bits.
- NPIPE, 2, register stages inside the popcount tree (legal 0..3).
- NACC_LOG2, 8, calibration averages 2**NACC_LOG2 samples (legal 1..12).

Ports:
- clk  in  1  slice clock.
- rst  in  1  synchronous reset, active-high.
- therm_in  in  2**NADC-1  TDC thermometer word; bit 0 is the first tap.
- sign_in  in  1  PFD sign; 1 = positive.
- valid_in  in  1  qualifies therm_in/sign_in.
- en_phase_reverse  in  1  request to invert the thermometer sense.
- ret_dly  in  2  extra retiming delay, 0..3 cycles.
- cal_start  in  1  one-cycle request to start a calibration average.
- data_out  out  NADC  unsigned count.
- sign_out  out  1  retimed sign.
- sdata_out  out  NADC+1  two's-complement signed result.
- valid_out  out  1  qualifies data_out, sign_out, sdata_out, therm_err.
- therm_err  out  1  non-thermometer pattern detected in this sample.
- cal_busy  out  1  high while accumulating.
- cal_done  out  1  one-cycle pulse when cal_mean updates.
- cal_mean  out  NADC+1  signed calibration mean.

Behaviour:
- Reset (rst=1 at a rising edge): every output, pipeline register, delay-line entry, phase-reverse synchroniser and accumulator goes to 0; FSM goes to IDLE. Reset has priority over all other inputs and takes effect mid-operation.
- Input stage: therm_in, sign_in and valid_in are registered at capture edge k.
- Phase reverse:
  - en_phase_reverse passes through two flops, pr_q1 then pr_q2.
  - A sample captured while pr_q2=1 is counted as ~therm_in.
  - A change at edge k applies to samples captured from edge k+2 onward.
- Popcount: count = number of ones (0..2**NADC-1); exact, no saturation. Split into NPIPE register stages; NPIPE=0 is fully combinational between input and output registers.
- Bubble detect: therm_err=1 if any bit i has bit i+1 set while bit i is clear, evaluated after inversion. The count is still the plain popcount.
- Sign and width:
  - sdata_out = sign ? +count : -count, NADC+1 bits.
  - count 0 gives 0 for either sign.
  - sign_out is the registered sign_in.
- Latency:
  - A sample captured at edge k appears on all outputs, with valid_out=1, after edge k+1+NPIPE+ret_dly.
  - Back-to-back valid_in gives back-to-back valid_out.
  - valid_in=0 samples propagate with valid_out=0; data outputs may change but are don't-care.
- Retimer: a 3-deep delay line after the output register; ret_dly selects the tap. Changing ret_dly while valid samples are in flight may duplicate or drop up to 3 samples, never X. Bench changes it only when idle.
- Calibration FSM:
  - IDLE: cal_busy=0. On cal_start=1, clear the accumulator and sample counter, then go to ACCUM.
  - ACCUM: cal_busy=1. On each valid_out=1 cycle, add sign-extended sdata_out to an accumulator of NADC+1+NACC_LOG2 bits (cannot overflow). After the 2**NACC_LOG2-th add, go to DONE.
  - DONE, one cycle: cal_mean = acc >>> NACC_LOG2 (arithmetic shift, floor toward -inf); cal_done=1; cal_busy=0. Next state is IDLE.
  - cal_start is ignored in ACCUM and DONE. A cal_start in IDLE on the same edge as a valid_out sample does not count that sample.
  - cal_mean holds its value between runs. Reset during ACCUM gives IDLE with cal_mean=0 and no cal_done.

Test Plan:
- Reset: hold rst=1 for 3 cycles with random inputs -> all outputs 0, cal_busy=0; after release with valid_in=0, valid_out stays 0.
- Latency (NADC=8, NPIPE=2): therm_in = lower 100 bits set, sign_in=1, single valid pulse at edge k, ret_dly=0 -> valid_out only after edge k+3, data_out=100, sdata_out=+100. Repeat with ret_dly=3 -> edge k+6.
- Sign and bounds: 37 ones with sign 0 -> sdata_out=9'h1DB (-37). All 255 ones with sign 0 -> -255 (9'h101). All zeros -> 0 with either sign.
- Phase reverse: 100 ones streamed every cycle, en_phase_reverse rises at edge k -> samples captured at k and k+1 give 100; from k+2 onward give 155. Deassert -> returns to 100 two captures later.
- Bubble: bits 0..9 set except bit 4 -> data_out=9, therm_err=1. Clean 10-bit thermometer -> therm_err=0.
- Calibration (NACC_LOG2=4):
  - 16 samples alternating +10/-3 -> sum 56, cal_mean=3, single cal_done pulse, cal_busy low the same cycle.
  - 16 samples of -1 -> cal_mean=-1.
  - cal_start while busy -> no restart.
  - rst after 8 samples -> cal_busy=0, cal_mean=0, no cal_done.
